aes_encrypt_core: RTL and testbench

//  Iterative AES-128 encryption engine; forward counterpart of the decrypt round chain.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_encrypt_core_if.sv | 25 ++
 rtl/aes_sbox.sv | 12 +
 rtl/aes_encrypt_core.sv | 128 ++++++++++++
 tb/tb_aes_encrypt_core.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and GF(2^8) helpers.
// Bytes are numbered from the MSB: [0:7] is byte 0.
package aes_pkg;

    typedef logic [0:127] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } enc_fsm_e;

    // Round constants; entry 0 and entries past 10 are unused padding.
    localparam logic [0:127] RCON =
        128'h00010204_08102040_801b3600_00000000;

    // Forward S-box, entry n at bits [8n +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_column(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// Host-side block handshake: plaintext/key in, ciphertext out.
// The core connects through the slave modport.
interface aes_encrypt_core_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t key;
    aes_state_t plaintext;
    logic       out_valid;
    logic       out_ready;
    aes_state_t ciphertext;
    logic       busy;

    modport master (
        output in_valid, key, plaintext, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, key, plaintext, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 8-bit lookup.
// Pure table read, no state.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = SBOX[{in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock,
// round keys expanded on the fly alongside the state.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int NR      = 10,
    parameter bit ZEROIZE = 1'b1
)
(
    input  logic              Clk,
    input  logic              Reset_n,
    aes_encrypt_core_if.slave bus
);

    if (NR != 10) begin : g_nr_chk
        $error("aes_encrypt_core: only NR=10 is supported");
    end

    localparam logic [3:0] LAST = 4'(NR);

    enc_fsm_e   fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    aes_state_t rk_q, rk_d;
    logic [3:0] round_q, round_d;

    aes_state_t sb, sr, mc, rk_next, rnd_out;
    logic [0:31] w3, sw, kw0, kw1, kw2, kw3;
    logic [7:0]  rcon;

    genvar i, r, c;

    for (i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (
            .in_i  (state_q[8*i +: 8]),
            .out_o (sb[8*i +: 8])
        );
    end

    // RotWord folded into the SubWord input wiring.
    for (i = 0; i < 4; i++) begin : g_sw
        aes_sbox u_sw (
            .in_i  (w3[8*((i+1)%4) +: 8]),
            .out_o (sw[8*i +: 8])
        );
    end

    for (r = 0; r < 4; r++) begin : g_row
        for (c = 0; c < 4; c++) begin : g_col
            assign sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
        end
    end

    for (c = 0; c < 4; c++) begin : g_mix
        assign mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end

    assign w3      = rk_q[96:127];
    assign rcon    = RCON[{round_q, 3'b000} +: 8];
    assign kw0     = rk_q[0:31] ^ sw ^ {rcon, 24'h000000};
    assign kw1     = rk_q[32:63] ^ kw0;
    assign kw2     = rk_q[64:95] ^ kw1;
    assign kw3     = rk_q[96:127] ^ kw2;
    assign rk_next = {kw0, kw1, kw2, kw3};

    // The last round skips MixColumns.
    assign rnd_out = ((round_q == LAST) ? sr : mc) ^ rk_next;

    assign bus.ciphertext = state_q;

    // Next-state and handshake outputs; outputs depend on fsm_q only.
    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        rk_d          = rk_q;
        round_d       = round_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = bus.plaintext ^ bus.key;
                    rk_d    = bus.key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                bus.busy = 1'b1;
                state_d  = rnd_out;
                rk_d     = rk_next;
                round_d  = round_q + 4'd1;
                if (round_q == LAST) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                    if (ZEROIZE) begin
                        state_d = '0;
                        rk_d    = '0;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, round key, round counter and FSM registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core using FIPS-197 vectors,
// back-pressure, busy-time input, mid-round reset and back-to-back.
module tb_aes_encrypt_core;
    import aes_pkg::*;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic Clk;
    logic Reset_n;
    int   n_chk;
    int   n_fail;

    aes_encrypt_core_if bus_if ();

    aes_encrypt_core #(.NR(10), .ZEROIZE(1'b1)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_if)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_in_ready"}, bus_if.in_ready, 1'b1);
        chk1({tag, "_out_valid"}, bus_if.out_valid, 1'b0);
        chk1({tag, "_busy"}, bus_if.busy, 1'b0);
        chkw({tag, "_ct"}, bus_if.ciphertext, 128'h0);
    endtask

    initial begin
        n_chk            = 0;
        n_fail           = 0;
        Reset_n          = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.key       = '0;
        bus_if.plaintext = '0;
        bus_if.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge Clk);
        chk_idle("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // Test 1 + 3: App.B vector, latency, then back-pressure
        bus_if.in_valid  = 1'b1;
        bus_if.key       = K1;
        bus_if.plaintext = P1;
        @(negedge Clk);
        bus_if.in_valid = 1'b0;
        chk1("t1_busy", bus_if.busy, 1'b1);
        chk1("t1_in_ready", bus_if.in_ready, 1'b0);
        repeat (9) @(negedge Clk);
        chk1("t1_ov_edge9", bus_if.out_valid, 1'b0);
        @(negedge Clk);
        chk1("t1_ov_edge10", bus_if.out_valid, 1'b1);
        chk1("t1_busy_done", bus_if.busy, 1'b0);
        chkw("t1_ct", bus_if.ciphertext, C1);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            chk1("t3_hold_ov", bus_if.out_valid, 1'b1);
            chk1("t3_hold_in_ready", bus_if.in_ready, 1'b0);
            chkw("t3_hold_ct", bus_if.ciphertext, C1);
        end
        bus_if.out_ready = 1'b1;
        @(negedge Clk);
        bus_if.out_ready = 1'b0;
        chk_idle("t3_release");
        @(negedge Clk);
        chk1("t3_single_ov", bus_if.out_valid, 1'b0);

        // Test 4: in_valid held with changing data while busy
        bus_if.in_valid  = 1'b1;
        bus_if.key       = K1;
        bus_if.plaintext = P1;
        @(negedge Clk);
        for (int k = 0; k < 10; k++) begin
            bus_if.key       = K2 ^ 128'(k);
            bus_if.plaintext = ~P1 + 128'(k);
            if (k < 9) @(negedge Clk);
        end
        bus_if.in_valid = 1'b0;
        @(negedge Clk);
        chk1("t4_ov", bus_if.out_valid, 1'b1);
        chkw("t4_ct", bus_if.ciphertext, C1);
        bus_if.out_ready = 1'b1;
        @(negedge Clk);
        bus_if.out_ready = 1'b0;
        chk_idle("t4_idle");

        // Test 5: reset at round 5, then C.1 vector
        bus_if.in_valid  = 1'b1;
        bus_if.key       = K2;
        bus_if.plaintext = P2;
        @(negedge Clk);
        bus_if.in_valid = 1'b0;
        repeat (5) @(negedge Clk);
        chk1("t5_busy_pre", bus_if.busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk_idle("t5_reset");
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        chk_idle("t5_after");
        bus_if.in_valid = 1'b1;
        @(negedge Clk);
        bus_if.in_valid = 1'b0;
        repeat (10) @(negedge Clk);
        chk1("t5_ov", bus_if.out_valid, 1'b1);
        chkw("t5_ct", bus_if.ciphertext, C2);
        bus_if.out_ready = 1'b1;
        @(negedge Clk);
        bus_if.out_ready = 1'b0;
        chk_idle("t5_idle");

        // Test 6: back-to-back, out_ready tied high
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.key       = K1;
        bus_if.plaintext = P1;
        @(negedge Clk);
        bus_if.key       = K2;
        bus_if.plaintext = P2;
        chk1("t6_busy_a", bus_if.busy, 1'b1);
        repeat (9) @(negedge Clk);
        chk1("t6_ov_a9", bus_if.out_valid, 1'b0);
        @(negedge Clk);
        chk1("t6_ov_a", bus_if.out_valid, 1'b1);
        chkw("t6_ct_a", bus_if.ciphertext, C1);
        @(negedge Clk);
        chk_idle("t6_gap");
        @(negedge Clk);
        bus_if.in_valid = 1'b0;
        chk1("t6_busy_b", bus_if.busy, 1'b1);
        repeat (9) @(negedge Clk);
        chk1("t6_ov_b9", bus_if.out_valid, 1'b0);
        @(negedge Clk);
        chk1("t6_ov_b", bus_if.out_valid, 1'b1);
        chkw("t6_ct_b", bus_if.ciphertext, C2);
        @(negedge Clk);
        chk_idle("t6_end");
        bus_if.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
